// File: rtl/traffic_isect_ctrl_if.sv
// traffic_isect_ctrl_if: pedestrian request plus lamp/phase bundle; TFLT_PED_EN selects pedestrian support in the controller
interface traffic_isect_ctrl_if;
    logic       ped_req;
    logic       ns_r, ns_y, ns_g;
    logic       ew_r, ew_y, ew_g;
    logic       walk;
    logic [2:0] phase;
    modport master (input ped_req, output ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk, phase);
    modport slave (output ped_req, input ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk, phase);
endinterface

// File: rtl/traffic_isect_ctrl.sv
// traffic_isect_ctrl: two-way intersection lamp sequencer with optional pedestrian walk phase (enabled by TFLT_PED_EN)
module traffic_isect_ctrl #(
    parameter int GRN_CYC  = 15,
    parameter int YEL_CYC  = 2,
    parameter int AR_CYC   = 1,
    parameter int WALK_CYC = 8,
    parameter int CNT_W    = 4
) (
    input logic clk,
    input logic rst,
    traffic_isect_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        NS_GRN = 3'd1,
        NS_YEL = 3'd2,
        AR_A   = 3'd3,
        EW_GRN = 3'd4,
        EW_YEL = 3'd5,
        AR_B   = 3'd6,
        WALK   = 3'd7
    } state_t;

    state_t             state, state_n, nxt;
    logic [CNT_W-1:0]   timer, timer_n, dur;
    logic               go;

`ifdef TFLT_PED_EN
    logic ped_pend;
    // latch pedestrian requests until the walk phase consumes them; requests during WALK are ignored
    always_ff @(posedge clk) begin
        if (rst) ped_pend <= 1'b0;
        else     ped_pend <= (state == WALK) ? 1'b0 : ped_pend | bus.ped_req;
    end
`else
    logic unused_ped;
    assign unused_ped = bus.ped_req;
`endif

    // successor state, its duration, and whether this cycle ends the current phase
    always_comb begin
        nxt = IDLE;
        dur = '0;
        case (state)
            IDLE:   nxt = AR_B;
            NS_GRN: nxt = NS_YEL;
            NS_YEL: nxt = AR_A;
            AR_A:   nxt = EW_GRN;
            EW_GRN: nxt = EW_YEL;
            EW_YEL: nxt = AR_B;
`ifdef TFLT_PED_EN
            AR_B:   nxt = ped_pend ? WALK : NS_GRN;
            WALK:   nxt = NS_GRN;
`else
            AR_B:   nxt = NS_GRN;
`endif
            default: nxt = IDLE;
        endcase
        case (nxt)
            NS_GRN, EW_GRN: dur = CNT_W'(GRN_CYC - 1);
            NS_YEL, EW_YEL: dur = CNT_W'(YEL_CYC - 1);
            AR_A, AR_B:     dur = CNT_W'(AR_CYC - 1);
            WALK:           dur = CNT_W'(WALK_CYC - 1);
            default:        dur = '0;
        endcase
        go      = (timer == '0) || (nxt == IDLE);
        state_n = go ? nxt : state;
        timer_n = go ? dur : timer - CNT_W'(1);
    end

    // state and phase timer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_n;
            timer <= timer_n;
        end
    end

    assign bus.phase = state;
    assign bus.ns_g  = state == NS_GRN;
    assign bus.ns_y  = state == NS_YEL;
    assign bus.ew_g  = state == EW_GRN;
    assign bus.ew_y  = state == EW_YEL;
    assign bus.ns_r  = state inside {EW_GRN, EW_YEL, AR_A, AR_B, WALK};
    assign bus.ew_r  = state inside {NS_GRN, NS_YEL, AR_A, AR_B, WALK};
`ifdef TFLT_PED_EN
    assign bus.walk  = state == WALK;
`else
    assign bus.walk  = 1'b0;
`endif
endmodule

// File: tb/tb_traffic_isect_ctrl.sv
// tb_traffic_isect_ctrl: random stimulus against a phase-schedule queue model, default and all-ones timing instances
module tb_traffic_isect_ctrl;
`ifdef TFLT_PED_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req = 1'b0;
    int   tests = 0;
    int   fails = 0;
    byte  qa[$], qb[$];
    bit   pend[2];
    int   cur[2];
    bit   flag;
    int   n;

    always #5 clk = ~clk;

    traffic_isect_ctrl_if bus ();
    traffic_isect_ctrl_if bus_f ();
    assign bus.ped_req   = req;
    assign bus_f.ped_req = req;

    traffic_isect_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
    traffic_isect_ctrl #(.GRN_CYC(1), .YEL_CYC(1), .AR_CYC(1), .WALK_CYC(1), .CNT_W(1))
        dut_f (.clk(clk), .rst(rst), .bus(bus_f));

    assert property (@(posedge clk) !(bus.ns_g && bus.ew_g));
    assert property (@(posedge clk) !(bus_f.ns_g && bus_f.ew_g));

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int dur(input int k, input int p);
        if (k == 1) return 1;
        case (p)
            1, 4: return 15;
            2, 5: return 2;
            7:    return 8;
            default: return 1;
        endcase
    endfunction

    // {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk} for each phase code
    function automatic logic [7:0] lamps_of(input int p);
        case (p)
            1:       return 8'b0011000;
            2:       return 8'b0101000;
            3, 6:    return 8'b1001000;
            4:       return 8'b1000010;
            5:       return 8'b1000100;
            7:       return 8'b1001001;
            default: return 8'b0000000;
        endcase
    endfunction

    task automatic push(input int k, input int p, input int cnt);
        repeat (cnt) begin
            if (k == 0) qa.push_back(byte'(p));
            else        qb.push_back(byte'(p));
        end
    endtask

    task automatic m_reset(input int k);
        if (k == 0) qa.delete();
        else        qb.delete();
        pend[k] = 1'b0;
        push(k, 0, 1);
        push(k, 6, dur(k, 6));
    endtask

    task automatic m_loop(input int k);
        if (PED && pend[k]) push(k, 7, dur(k, 7));
        for (int p = 1; p <= 6; p++) push(k, p, dur(k, p));
    endtask

    task automatic chk();
        logic [7:0] ph, lp;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                cur[0] = (qa.size() > 0) ? int'(qa.pop_front()) : 0;
                ph = {5'd0, bus.phase};
                lp = {1'b0, bus.ns_r, bus.ns_y, bus.ns_g, bus.ew_r, bus.ew_y, bus.ew_g, bus.walk};
                check("phase", ph, 8'(cur[0]));
                check("lamps", lp, lamps_of(cur[0]));
            end else begin
                cur[1] = (qb.size() > 0) ? int'(qb.pop_front()) : 0;
                ph = {5'd0, bus_f.phase};
                lp = {1'b0, bus_f.ns_r, bus_f.ns_y, bus_f.ns_g, bus_f.ew_r, bus_f.ew_y, bus_f.ew_g, bus_f.walk};
                check("phase_fast", ph, 8'(cur[1]));
                check("lamps_fast", lp, lamps_of(cur[1]));
            end
        end
    endtask

    task automatic drv(input bit r, input bit q);
        rst = r;
        req = q;
        for (int k = 0; k < 2; k++) begin
            if (r) m_reset(k);
            else begin
                if ((k == 0 ? qa.size() : qb.size()) == 0) m_loop(k);
                pend[k] = (cur[k] == 7) ? 1'b0 : (pend[k] | q);
            end
        end
    endtask

    initial begin
        m_reset(0);
        m_reset(1);
        repeat (3) begin chk(); drv(1'b1, 1'($urandom_range(0, 1))); end
        repeat (80) begin chk(); drv(1'b0, 1'b0); end
        flag = 1'b0;
        repeat (100) begin
            chk();
            drv(1'b0, !flag && cur[0] == 4);
            if (cur[0] == 4) flag = 1'b1;
        end
        flag = 1'b0;
        repeat (120) begin
            chk();
            if (cur[0] == 7) flag = 1'b1;
            drv(1'b0, !(flag && cur[0] != 7));
        end
        flag = 1'b0;
        repeat (100) begin
            chk();
            drv(1'b0, !flag && cur[0] == 1);
            if (cur[0] == 1) flag = 1'b1;
        end
        flag = 1'b0;
        n = 0;
        repeat (120) begin
            chk();
            if (cur[0] == 1 && !flag) n++;
            drv(!flag && n == 6, !flag && n == 1);
            if (n == 6) flag = 1'b1;
        end
        repeat (700) begin
            chk();
            drv($urandom_range(0, 149) == 0, $urandom_range(0, 5) == 0);
        end
        chk();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
